// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling window front end.
package pool_pkg;

    localparam int unsigned DefPixW = 4;
    localparam int unsigned DefImgW = 28;
    localparam int unsigned DefImgH = 28;

    typedef enum logic {
        StTop = 1'b0,
        StBot = 1'b1
    } state_e;

endpackage

// File: rtl/pool_line_buf.sv
// One image row of pixels: single write port, two combinational read ports.
module pool_line_buf #(
    parameter int unsigned Depth = 28,
    parameter int unsigned PIX_W = 4,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic [PIX_W-1:0] wr_data_i,
    input  logic [AddrW-1:0] rd_addr_a_i,
    output logic [PIX_W-1:0] rd_data_a_o,
    input  logic [AddrW-1:0] rd_addr_b_i,
    output logic [PIX_W-1:0] rd_data_b_o
);

    // No reset: every entry is written on an even row before an odd row reads it.
    logic [PIX_W-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_a_o = mem[rd_addr_a_i];
        rd_data_b_o = mem[rd_addr_b_i];
    end

endmodule

// File: rtl/pool_window_gen.sv
// Raster pixel stream to non-overlapping 2x2 windows for the max-pool stage.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int unsigned IMG_W = DefImgW,
    parameter int unsigned IMG_H = DefImgH,
    parameter int unsigned PIX_W = DefPixW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [PIX_W-1:0] pixel1,
    output logic [PIX_W-1:0] pixel2,
    output logic [PIX_W-1:0] pixel3,
    output logic [PIX_W-1:0] pixel4,
    output logic             win_last,
    output logic             frame_done
);

    localparam int unsigned ColW = $clog2(IMG_W);
    localparam int unsigned RowW = $clog2(IMG_H);

    if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : gen_bad_dims
        $error("pool_window_gen: IMG_W and IMG_H must be even and at least 2");
    end

    state_e           state_q, state_d;
    logic [ColW-1:0]  col_q, col_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [PIX_W-1:0] hold_q, hold_d;
    logic [PIX_W-1:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, p4_q, p4_d;
    logic             win_valid_q, win_valid_d;
    logic             win_last_q, win_last_d;

    logic             accept, last_col, last_row, load, buf_we;
    logic [ColW-1:0]  rd_left_addr;
    logic [PIX_W-1:0] buf_left, buf_right;

    pool_line_buf #(
        .Depth (IMG_W),
        .PIX_W (PIX_W),
        .AddrW (ColW)
    ) u_line_buf (
        .clk_i       (clk),
        .wr_en_i     (buf_we),
        .wr_addr_i   (col_q),
        .wr_data_i   (in_pixel),
        .rd_addr_a_i (rd_left_addr),
        .rd_data_a_o (buf_left),
        .rd_addr_b_i (col_q),
        .rd_data_b_o (buf_right)
    );

    always_comb begin
        in_ready     = !win_valid_q || win_ready;
        accept       = in_valid && in_ready;
        last_col     = (col_q == ColW'(IMG_W - 1));
        last_row     = (row_q == RowW'(IMG_H - 1));
        buf_we       = accept && (state_q == StTop);
        load         = accept && (state_q == StBot) && col_q[0];
        // A window completes on an odd column, so its left column is col with bit 0 cleared.
        rd_left_addr = col_q & ~ColW'(1);
        frame_done   = win_valid_q && win_ready && win_last_q;
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        p3_d        = p3_q;
        p4_d        = p4_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;

        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        unique case (state_q)
            StTop: begin
                if (accept && last_col) begin
                    state_d = StBot;
                end
            end
            StBot: begin
                if (accept && !col_q[0]) begin
                    hold_d = in_pixel;
                end
                if (accept && last_col) begin
                    state_d = StTop;
                end
            end
            default: state_d = StTop;
        endcase

        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
        // A new load in the same cycle as an accept overrides the clear.
        if (load) begin
            win_valid_d = 1'b1;
            win_last_d  = last_row && last_col;
            p1_d        = buf_left;
            p2_d        = buf_right;
            p3_d        = hold_q;
            p4_d        = in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StTop;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            p3_q        <= '0;
            p4_q        <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            p3_q        <= p3_d;
            p4_q        <= p4_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign pixel1    = p1_q;
    assign pixel2    = p2_q;
    assign pixel3    = p3_q;
    assign pixel4    = p4_q;

endmodule
